eth_frame_encap: RTL and testbench
==================================

# eth_frame_encap

Transmit-side Ethernet framing stage sitting directly upstream of the GMII transmit buffer. On a start request it emits a complete 802.3 frame as a byte stream on `buf_d`/`buf_dv`:
- preamble and SFD
- destination MAC, source MAC, EtherType
- payload streamed in from the host side
- zero padding to the 46-byte minimum
- CRC-32 FCS

It honours the buffer's `full` back-pressure and never drops or duplicates a byte.

## Interface
- `SRC_MAC`, default 48'h02_00_00_00_00_01, source MAC inserted in every frame
- `MAX_PAYLOAD`, default 1500, largest accepted `payload_len`
- `MIN_PAYLOAD`, default 46, payload size below which zero padding is appended

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-low
- `start`  in  1  one-cycle frame request; sampled only in IDLE
- `dst_mac`  in  48  destination MAC, latched on accepted start
- `eth_type`  in  16  EtherType/length field, latched on accepted start
- `payload_len`  in  11  payload byte count (0..MAX_PAYLOAD), latched on accepted start
- `pl_data`  in  8  payload byte
- `pl_valid`  in  1  `pl_data` valid
- `pl_ready`  out  1  payload byte accepted when `pl_valid && pl_ready`
- `buf_d`  out  8  frame byte to GMII buffer
- `buf_dv`  out  1  `buf_d` valid; each high cycle is exactly one byte
- `full`  in  1  GMII buffer cannot take more bytes
- `busy`  out  1  state != IDLE
- `done`  out  1  one-cycle pulse, frame complete
- `err`  out  1  one-cycle pulse, start rejected (`payload_len > MAX_PAYLOAD`)

## Operation
- **States and byte counts:**
  - IDLE
  - PRE: 7 bytes 0x55
  - SFD: 1 byte 0xD5
  - DST: 6 bytes
  - SRC: 6 bytes
  - TYPE: 2 bytes
  - PAY: `payload_len` bytes; skipped if 0
  - PAD: `MIN_PAYLOAD - payload_len` bytes 0x00 if positive, else skipped
  - FCS: 4 bytes
  - back to IDLE
- **Transition rule:** every state transition happens after its last byte is issued. Byte counter is 11 bits and resets at each state entry.
- **Field byte order:** MACs and `eth_type` go MSB byte first (`dst_mac[47:40]` first, `SRC_MAC[47:40]` first, `eth_type[15:8]` first).
- **CRC-32:**
  - Reflected polynomial 0xEDB88320, LSB-first per byte, init 0xFFFFFFFF.
  - Updated on every byte issued in DST through PAD.
  - Preamble and SFD are excluded.
  - FCS = ~crc, issued `fcs[7:0]` first, then `[15:8]`, `[23:16]`, `[31:24]`.
  - Combinational byte-wide update (8 unrolled steps).
- **Issue rule:** a byte is issued at a clock edge when `full == 0` and a byte is available. Availability is always true outside PAY; in PAY it is `pl_valid`. The issued byte appears registered on `buf_d` with `buf_dv = 1` in the following cycle. Otherwise `buf_dv = 0` next cycle and the state and counter hold.
- `pl_ready = (state == PAY) && !full`, combinational.
- **Back-pressure margin:** the GMII buffer asserts `full` with at least one free slot, because the byte registered on the edge where `full` was sampled low is always delivered.
- **Start handling:**
  - `start` in IDLE with `payload_len <= MAX_PAYLOAD`: latch fields, reset CRC, go to PRE.
  - `payload_len > MAX_PAYLOAD`: pulse `err`, stay IDLE, no `buf_dv`.
  - `start` while busy is ignored (no `err`).
- **Frame length:** bytes per frame = 26 + max(`payload_len`, `MIN_PAYLOAD`). Range 72..1526 with defaults.
- **Reset:** `rst` low mid-frame aborts.
  - Next cycle: IDLE, all outputs low.
  - CRC reloads to 0xFFFFFFFF; counters and latched fields are cleared.
  - Partially sent frame bytes already in the buffer are the buffer's concern.

## Timing
- **Reset values:** `buf_d = 0`, `buf_dv = 0`, `pl_ready = 0`, `busy = 0`, `done = 0`, `err = 0`.
- **Start to first byte:** `start` accepted at edge N → `busy = 1` and first 0x55 on `buf_d` with `buf_dv = 1` in cycle N+1, provided `full = 0` at edge N.
- **Throughput:** no stalls means one byte per cycle; a 46-byte-payload frame occupies 72 consecutive `buf_dv` cycles.
- **Completion:** `done` pulses in the same cycle `buf_dv` presents the last FCS byte. `busy` falls the next cycle.
- **Back-to-back frames:** a new `start` is accepted in the first IDLE cycle, so the minimum gap between frames' `buf_dv` is 1 cycle. IFG is enforced downstream.
- `err` pulses the cycle after the rejected `start`.

## Test plan
- **Padded frame:** `payload_len = 0`, `dst_mac` = FF..FF, `eth_type` = 0x0806, `full = 0` → 72 bytes: 7×0x55, 0xD5, FF×6, 02 00 00 00 00 01, 08 06, 46×0x00, FCS. A bench CRC register (init 0xFFFFFFFF, no final inversion) run over DST..FCS must end at 0xDEBB20E3. `done` coincides with byte 72.
- **Full-size frame:** `payload_len = 1500`, incrementing payload, `pl_valid` always high → 1526 bytes, no PAD, payload in order, FCS matches software model, `busy` for 1526 cycles.
- **Back-pressure:** `payload_len = 60`; hold `full = 1` for 5 cycles during DST and 3 cycles during PAY → `buf_dv` low in each following cycle, `pl_ready` low while `full`. Byte sequence identical to the unstalled run.
- **Payload gaps:** `pl_valid` toggling 1-0-1-0 with `payload_len = 10` → `buf_dv` gaps mirror the toggling, 10 payload bytes then 36 pad bytes, correct FCS.
- **Rejection:** `payload_len = 1501` → `err` = 1 for one cycle, `busy` stays 0, no `buf_dv`. `start` pulsed mid-frame → ignored, frame unaffected.
- **Reset mid-frame:** `rst` low for 1 cycle mid-PAY → all outputs 0 next cycle. A subsequent start with `payload_len = 46` yields a clean 72-byte frame with correct FCS.

Source files
------------

// File: rtl/eth_frame_encap.sv
// Transmit-side Ethernet framing stage: wraps a streamed payload into a full 802.3 frame
// (preamble, SFD, header, payload, zero pad, CRC-32 FCS) and honours GMII buffer back-pressure.
module eth_frame_encap #(
   parameter logic [47:0] SRC_MAC     = 48'h02_00_00_00_00_01,
   parameter int unsigned MAX_PAYLOAD = 1500,
   parameter int unsigned MIN_PAYLOAD = 46
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [47:0] dst_mac,
   input  logic [15:0] eth_type,
   input  logic [10:0] payload_len,
   input  logic [7:0]  pl_data,
   input  logic        pl_valid,
   output logic        pl_ready,
   output logic [7:0]  buf_d,
   output logic        buf_dv,
   input  logic        full,
   output logic        busy,
   output logic        done,
   output logic        err
);

   localparam logic [10:0] MAX_LEN = 11'(MAX_PAYLOAD);
   localparam logic [10:0] MIN_LEN = 11'(MIN_PAYLOAD);

   typedef enum logic [3:0] {
      S_IDLE, S_PRE, S_SFD, S_DST, S_SRC, S_TYPE, S_PAY, S_PAD, S_FCS
   } state_t;

   state_t      state, state_nx, after;
   logic [10:0] cnt, cnt_nx, len_r, pad_len;
   logic [47:0] dst_r;
   logic [15:0] type_r;
   logic [31:0] crc, crc_nx;
   logic [7:0]  byte_nx;
   logic        issue, last, accept, done_nx, err_nx;

   // Reflected CRC-32, one byte per call, LSB first.
   function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] d);
      logic [31:0] c;
      c = c_in ^ {24'd0, d};
      for (int unsigned i = 0; i < 8; i++)
         c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      return c;
   endfunction

   assign pl_ready = (state == S_PAY) && !full;
   // The done cycle still counts as busy so a new start is taken one cycle later.
   assign busy     = (state != S_IDLE) || done;

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      crc_nx   = crc;
      issue    = 1'b0;
      byte_nx  = '0;
      done_nx  = 1'b0;
      err_nx   = 1'b0;
      accept   = 1'b0;
      last     = 1'b0;
      after    = S_IDLE;
      pad_len  = MIN_LEN - len_r;

      case (state)
         S_PRE:  begin byte_nx = 8'h55; last = (cnt == 11'd6); after = S_SFD; end
         S_SFD:  begin byte_nx = 8'hD5; last = 1'b1;           after = S_DST; end
         S_DST:  begin
            byte_nx = 8'(dst_r >> {3'd5 - cnt[2:0], 3'b000});
            last    = (cnt == 11'd5);
            after   = S_SRC;
         end
         S_SRC:  begin
            byte_nx = 8'(SRC_MAC >> {3'd5 - cnt[2:0], 3'b000});
            last    = (cnt == 11'd5);
            after   = S_TYPE;
         end
         S_TYPE: begin
            byte_nx = cnt[0] ? type_r[7:0] : type_r[15:8];
            last    = (cnt == 11'd1);
            after   = (len_r != 11'd0) ? S_PAY : ((len_r < MIN_LEN) ? S_PAD : S_FCS);
         end
         S_PAY:  begin
            byte_nx = pl_data;
            last    = (cnt == len_r - 11'd1);
            after   = (len_r < MIN_LEN) ? S_PAD : S_FCS;
         end
         S_PAD:  begin last = (cnt == pad_len - 11'd1); after = S_FCS; end
         S_FCS:  begin
            byte_nx = 8'(~crc >> {cnt[1:0], 3'b000});
            last    = (cnt == 11'd3);
            after   = S_IDLE;
         end
         default: ;
      endcase

      if (state == S_IDLE) begin
         // The start edge itself already issues the first preamble byte.
         byte_nx = 8'h55;
         if (start && !done) begin
            if (payload_len > MAX_LEN) begin
               err_nx = 1'b1;
            end else begin
               accept   = 1'b1;
               state_nx = S_PRE;
               crc_nx   = '1;
               issue    = !full;
               cnt_nx   = full ? 11'd0 : 11'd1;
            end
         end
      end else begin
         issue = !full && ((state != S_PAY) || pl_valid);
         if (issue) begin
            if (state inside {S_DST, S_SRC, S_TYPE, S_PAY, S_PAD})
               crc_nx = crc_byte(crc, byte_nx);
            if (last) begin
               state_nx = after;
               cnt_nx   = '0;
               done_nx  = (state == S_FCS);
            end else begin
               cnt_nx = cnt + 11'd1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state  <= S_IDLE;
         cnt    <= '0;
         crc    <= '1;
         len_r  <= '0;
         dst_r  <= '0;
         type_r <= '0;
         buf_d  <= '0;
         buf_dv <= 1'b0;
         done   <= 1'b0;
         err    <= 1'b0;
      end else begin
         state  <= state_nx;
         cnt    <= cnt_nx;
         crc    <= crc_nx;
         buf_dv <= issue;
         done   <= done_nx;
         err    <= err_nx;
         if (issue)
            buf_d <= byte_nx;
         if (accept) begin
            len_r  <= payload_len;
            dst_r  <= dst_mac;
            type_r <= eth_type;
         end
      end
   end

endmodule

// File: tb/tb_eth_frame_encap.sv
// Self-checking bench for eth_frame_encap: directed frame scenarios compared byte-for-byte
// against a frame built from the framing rules, with a bit-serial CRC-32 reference.
module tb_eth_frame_encap;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [47:0] dst_mac;
   logic [15:0] eth_type;
   logic [10:0] payload_len;
   logic [7:0]  pl_data;
   logic        pl_valid;
   logic        pl_ready;
   logic [7:0]  buf_d;
   logic        buf_dv;
   logic        full;
   logic        busy;
   logic        done;
   logic        err;

   eth_frame_encap #(
      .SRC_MAC    (48'h02_00_00_00_00_01),
      .MAX_PAYLOAD(1500),
      .MIN_PAYLOAD(46)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .dst_mac(dst_mac), .eth_type(eth_type),
      .payload_len(payload_len), .pl_data(pl_data), .pl_valid(pl_valid), .pl_ready(pl_ready),
      .buf_d(buf_d), .buf_dv(buf_dv), .full(full), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   localparam logic [47:0] SRC = 48'h02_00_00_00_00_01;

   int nchk = 0, nerr = 0;
   logic [7:0] pay [0:1499];
   logic [7:0] exp_q [$];
   logic [7:0] cap [$];
   int cur_len, pidx, cyc, done_cnt, done_pos, busy_cnt, err_cnt;
   int w1lo = -10, w1hi = -10, w2lo = -10, w2hi = -10, mid_start_at = -1;
   bit inc_pay = 0, toggle = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      nchk++;
      assert (obs === expv) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Bit-serial reflected CRC-32 over q[from..q.size()-1], no final inversion.
   function automatic logic [31:0] ref_crc(input logic [7:0] q [$], input int from);
      logic [31:0] c = 32'hFFFF_FFFF;
      for (int k = from; k < q.size(); k++)
         for (int b = 0; b < 8; b++) begin
            logic fb;
            fb = c[0] ^ q[k][b];
            c  = (c >> 1) ^ (fb ? 32'hEDB8_8320 : 32'h0);
         end
      return c;
   endfunction

   task automatic build_expected(input int len, input logic [47:0] dst, input logic [15:0] typ);
      logic [31:0] fcs;
      exp_q.delete();
      repeat (7) exp_q.push_back(8'h55);
      exp_q.push_back(8'hD5);
      for (int i = 5; i >= 0; i--) exp_q.push_back(8'((dst >> (8 * i)) & 48'hFF));
      for (int i = 5; i >= 0; i--) exp_q.push_back(8'((SRC >> (8 * i)) & 48'hFF));
      exp_q.push_back(typ[15:8]);
      exp_q.push_back(typ[7:0]);
      for (int i = 0; i < len; i++) exp_q.push_back(pay[i]);
      for (int i = len; i < 46; i++) exp_q.push_back(8'h00);
      fcs = ~ref_crc(exp_q, 8);
      for (int i = 0; i < 4; i++) exp_q.push_back(8'(fcs >> (8 * i)));
   endtask

   // One clock: record what the DUT shows after the edge, then set inputs for the next edge.
   task automatic cycle();
      logic hs, fs;
      hs = pl_valid && pl_ready;
      fs = full;
      @(posedge clk);
      #1;
      if (hs) pidx++;
      if (buf_dv) cap.push_back(buf_d);
      if (done) begin done_cnt++; done_pos = cap.size(); end
      if (busy) busy_cnt++;
      if (err) err_cnt++;
      if (fs) check("dv_after_full", buf_dv, 1'b0);
      cyc++;
      start = 1'b0;
      if (cyc == mid_start_at) begin
         start       = 1'b1;
         payload_len = 11'($urandom_range(0, 2047));
         dst_mac     = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
         eth_type    = 16'($urandom);
      end
      full     = (cyc >= w1lo && cyc <= w1hi) || (cyc >= w2lo && cyc <= w2hi);
      pl_valid = toggle ? (cyc % 2 == 0) : 1'b1;
      pl_data  = (pidx < cur_len) ? pay[pidx] : 8'($urandom);
      #1;
      if (full) check("ready_while_full", pl_ready, 1'b0);
   endtask

   task automatic run_frame(input int len, input logic [47:0] dst, input logic [15:0] typ,
                            input int exp_busy);
      int guard;
      cur_len = len;
      for (int i = 0; i < len; i++) pay[i] = inc_pay ? 8'(i) : 8'($urandom);
      build_expected(len, dst, typ);
      cap.delete();
      pidx = 0; cyc = 0; done_cnt = 0; done_pos = -1; busy_cnt = 0; err_cnt = 0;
      dst_mac = dst; eth_type = typ; payload_len = 11'(len); start = 1'b1;
      pl_valid = 1'b1;
      pl_data  = (len > 0) ? pay[0] : 8'h00;
      cycle();
      check("first_dv", buf_dv, 1'b1);
      check("first_byte", buf_d, 8'h55);
      check("first_busy", busy, 1'b1);
      guard = 0;
      while (done_cnt == 0 && guard < exp_q.size() + 64) begin
         cycle();
         guard++;
      end
      check("done_seen", done_cnt > 0, 1'b1);
      cycle();
      check("idle_busy", busy, 1'b0);
      check("idle_dv", buf_dv, 1'b0);
      check("done_once", done_cnt, 1);
      check("done_pos", done_pos, exp_q.size());
      check("err_quiet", err_cnt, 0);
      check("frame_len", cap.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < cap.size(); i++)
         check($sformatf("byte[%0d]", i), cap[i], exp_q[i]);
      if (exp_busy >= 0) check("busy_cycles", busy_cnt, exp_busy);
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; full = 1'b0; pl_valid = 1'b0; pl_data = '0;
      dst_mac = '0; eth_type = '0; payload_len = '0; cur_len = 0; pidx = 0; cyc = 0;
      cycle();
      cycle();
      check("rst_buf_d", buf_d, 8'h00);
      check("rst_buf_dv", buf_dv, 1'b0);
      check("rst_pl_ready", pl_ready, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_err", err, 1'b0);
      rst = 1'b1;
      cycle();

      // Minimum frame, all padding; residue over DST..FCS is the CRC-32 magic value.
      run_frame(0, 48'hFFFF_FFFF_FFFF, 16'h0806, 72);
      check("crc_residue", ref_crc(cap, 8), 32'hDEBB_20E3);

      // Largest frame, incrementing payload, back-to-back with the previous one.
      inc_pay = 1;
      run_frame(1500, 48'h0011_2233_4455, 16'h0800, 1526);
      inc_pay = 0;

      // Back-pressure: 5 stalled edges in DST, 3 in PAY.
      w1lo = 9; w1hi = 13; w2lo = 35; w2hi = 37;
      run_frame(60, {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF, 16'h86DD, 86 + 8);
      w1lo = -10; w1hi = -10; w2lo = -10; w2hi = -10;

      // Payload source toggling valid every cycle.
      toggle = 1;
      run_frame(10, 48'hA1B2_C3D4_E5F6, 16'h1234, -1);
      toggle = 0;

      // Oversized request is rejected.
      payload_len = 11'd1501; start = 1'b1;
      cycle();
      check("rej_err", err, 1'b1);
      check("rej_busy", busy, 1'b0);
      check("rej_dv", buf_dv, 1'b0);
      cycle();
      check("rej_err_clr", err, 1'b0);
      check("rej_dv2", buf_dv, 1'b0);

      // Start pulsed mid-frame must not disturb the frame in flight.
      mid_start_at = 40;
      run_frame(46, 48'h0A0B_0C0D_0E0F, 16'h88B5, 72);
      mid_start_at = -1;

      // Reset in the middle of PAY, then a clean frame.
      cur_len = 46;
      for (int i = 0; i < 46; i++) pay[i] = 8'($urandom);
      pidx = 0; cyc = 0;
      dst_mac = 48'h1234_5678_9ABC; eth_type = 16'h0800; payload_len = 11'd46; start = 1'b1;
      pl_valid = 1'b1; pl_data = pay[0];
      repeat (30) cycle();
      rst = 1'b0;
      cycle();
      check("abort_buf_d", buf_d, 8'h00);
      check("abort_buf_dv", buf_dv, 1'b0);
      check("abort_pl_ready", pl_ready, 1'b0);
      check("abort_busy", busy, 1'b0);
      check("abort_done", done, 1'b0);
      check("abort_err", err, 1'b0);
      rst = 1'b1;
      cycle();
      run_frame(46, 48'h1234_5678_9ABC, 16'h0800, 72);

      // A few random lengths around the padding boundary.
      for (int n = 0; n < 4; n++) begin
         int len;
         len = $urandom_range(40, 52);
         run_frame(len, {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF, 16'($urandom),
                   26 + ((len > 46) ? len : 46));
      end

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

endmodule
